update_across_bin: RTL
======================

Name: update_across_bin

Overview:
- Writes a solved bin's local results back into the global state RAMs once the bin solver finishes.
- Walks the bin's local variables: maps each local index to its global index through the bin var-map RAM, rebases its local decision level by base_lvl_i, and writes the assigned ones into the global vars-state RAM.
- Then copies the bin's local level states into the global lvls-state RAM at base_lvl_i+k.
- Writer counterpart of the backtrack path; shares the same state-RAM write ports through the apply_update_o mux select.

Parameters:
WIDTH_VARS, 12, width of variable counts/indices
WIDTH_LVL, 16, width of decision level
WIDTH_VAR_STATES, 19, var state word = {value[2:0], lvl[WIDTH_LVL-1:0]}; must equal WIDTH_LVL+3
WIDTH_LVL_STATES, 30, level state word width
ADDR_WIDTH_VARS_STATES, 9, global vars-state RAM address width
ADDR_WIDTH_LVLS_STATES, 9, global lvls-state RAM address width

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
start_update  in  1  one-cycle start pulse
apply_update_o  out  1  high while busy (IDLE excluded, DONE included); RAM mux select
done_update  out  1  one-cycle completion pulse
nv_bin  in  WIDTH_VARS  local variable count
nl_bin  in  WIDTH_LVL  local level count (levels 1..nl_bin)
base_lvl_i  in  WIDTH_LVL  global level offset of this bin
ram_raddr_vmap_o  out  WIDTH_VARS  var-map RAM read address (local index)
ram_rdata_vmap_i  in  ADDR_WIDTH_VARS_STATES  global var index; 1-cycle read latency
local_raddr_v_o  out  WIDTH_VARS  local var-state read address
local_rdata_v_i  in  WIDTH_VAR_STATES  local {value, lvl}; 1-cycle latency
local_raddr_l_o  out  WIDTH_LVL  local level-state read address
local_rdata_l_i  in  WIDTH_LVL_STATES  local level state; 1-cycle latency
ram_we_v_state_o, ram_waddr_v_state_o, ram_wdata_v_state_o  out  1/ADDR_WIDTH_VARS_STATES/WIDTH_VAR_STATES  global vars-state write
ram_we_l_state_o, ram_addr_l_state_o, ram_data_l_state_o  out  1/ADDR_WIDTH_LVLS_STATES/WIDTH_LVL_STATES  global lvls-state write
cur_lvl_o  out  WIDTH_LVL  registered base_lvl_i+nl_bin, updated in DONE

Behaviour:
- Reset:
  - All outputs are 0; the FSM goes to IDLE.
  - Reset asserted mid-operation aborts in the next cycle: no further writes and no done pulse.
- FSM states: IDLE, VARS, VDRAIN, LVLS, LDRAIN, DONE.
- IDLE:
  - On start_update, latch nv_bin, nl_bin and base_lvl_i.
  - Go to VARS if nv_bin!=0; else to LVLS if nl_bin!=0; else to DONE.
  - start_update is ignored in every state other than IDLE.
- VARS:
  - Counter k runs 0..nv_bin-1, one per cycle.
  - ram_raddr_vmap_o and local_raddr_v_o both equal k in the same cycle.
  - After issuing k=nv_bin-1, go to VDRAIN.
- Var pipeline:
  - Address issued at cycle t; data valid at t+1; registered write at t+2.
  - Write condition: value!=3'b000. Unassigned variables produce no write (we=0).
  - waddr = ram_rdata_vmap_i.
  - wdata = {value, lvl+base_lvl}, with the sum truncated to WIDTH_LVL (wrap is not checked).
  - lvl==0 (preassigned at level 0) is also rebased.
- VDRAIN:
  - Lasts 2 cycles so the last write retires.
  - Then go to LVLS if nl_bin!=0, else to DONE.
- LVLS:
  - Counter j runs 1..nl_bin; local_raddr_l_o=j.
  - Write at t+2: ram_addr_l_state_o = base_lvl+j, truncated to ADDR_WIDTH_LVLS_STATES; ram_data_l_state_o = local_rdata_l_i.
  - After issuing j=nl_bin, go to LDRAIN.
- LDRAIN: 2 cycles, then DONE.
- DONE:
  - done_update=1 for one cycle; cur_lvl_o updated; go to IDLE.
- apply_update_o: 1 from the cycle after start (first VARS/LVLS/DONE cycle) through DONE inclusive.
- When not writing, we=0 and the corresponding addr/data are 0.
- Var writes and level writes never overlap in the same cycle.
- Total latency, start to done: nv_bin + (nv_bin?2:0) + nl_bin + (nl_bin?2:0) + 1 cycles after the start cycle.

Test Plan:
1. nv_bin=3, nl_bin=0, base=5; vmap={7,2,9}; local={(3'b010,1),(0,0),(3'b100,2)}
   -> exactly 2 var writes: addr7 data {010,6} and addr9 data {100,7}.
   -> No writes to addr 2; done 6 cycles after start.
2. nv_bin=0, nl_bin=2, base=10, local lvl states {A,B}
   -> Level writes addr11=A, then addr12=B on consecutive cycles.
   -> cur_lvl_o=12; done 5 cycles after start.
3. nv_bin=0, nl_bin=0
   -> done_update the cycle after start; no writes; apply_update_o high for exactly 1 cycle.
4. base=16'hFFFF, local lvl=2
   -> Written lvl field = 1 (wrap); vmap index mapping unaffected.
5. rst low during VARS after 2 writes
   -> Outputs 0 next cycle, no done; a new start after reset behaves per test 1.
6. start_update pulsed again while in LVLS
   -> Ignored; single done; write sequence unchanged.

Source files
------------

// File: rtl/update_across_bin_if.sv
// Handshake and RAM-port bundle between the bin write-back engine and its environment.
interface update_across_bin_if #(
  parameter int WIDTH_VARS             = 12,
  parameter int WIDTH_LVL              = 16,
  parameter int WIDTH_VAR_STATES       = 19,
  parameter int WIDTH_LVL_STATES       = 30,
  parameter int ADDR_WIDTH_VARS_STATES = 9,
  parameter int ADDR_WIDTH_LVLS_STATES = 9
) ();
  logic                              start_update;
  logic                              apply_update_o;
  logic                              done_update;
  logic [WIDTH_VARS-1:0]             nv_bin;
  logic [WIDTH_LVL-1:0]              nl_bin;
  logic [WIDTH_LVL-1:0]              base_lvl_i;
  logic [WIDTH_VARS-1:0]             ram_raddr_vmap_o;
  logic [ADDR_WIDTH_VARS_STATES-1:0] ram_rdata_vmap_i;
  logic [WIDTH_VARS-1:0]             local_raddr_v_o;
  logic [WIDTH_VAR_STATES-1:0]       local_rdata_v_i;
  logic [WIDTH_LVL-1:0]              local_raddr_l_o;
  logic [WIDTH_LVL_STATES-1:0]       local_rdata_l_i;
  logic                              ram_we_v_state_o;
  logic [ADDR_WIDTH_VARS_STATES-1:0] ram_waddr_v_state_o;
  logic [WIDTH_VAR_STATES-1:0]       ram_wdata_v_state_o;
  logic                              ram_we_l_state_o;
  logic [ADDR_WIDTH_LVLS_STATES-1:0] ram_addr_l_state_o;
  logic [WIDTH_LVL_STATES-1:0]       ram_data_l_state_o;
  logic [WIDTH_LVL-1:0]              cur_lvl_o;

  modport master (
    input  start_update, nv_bin, nl_bin, base_lvl_i,
           ram_rdata_vmap_i, local_rdata_v_i, local_rdata_l_i,
    output apply_update_o, done_update,
           ram_raddr_vmap_o, local_raddr_v_o, local_raddr_l_o,
           ram_we_v_state_o, ram_waddr_v_state_o, ram_wdata_v_state_o,
           ram_we_l_state_o, ram_addr_l_state_o, ram_data_l_state_o,
           cur_lvl_o
  );

  modport slave (
    output start_update, nv_bin, nl_bin, base_lvl_i,
           ram_rdata_vmap_i, local_rdata_v_i, local_rdata_l_i,
    input  apply_update_o, done_update,
           ram_raddr_vmap_o, local_raddr_v_o, local_raddr_l_o,
           ram_we_v_state_o, ram_waddr_v_state_o, ram_wdata_v_state_o,
           ram_we_l_state_o, ram_addr_l_state_o, ram_data_l_state_o,
           cur_lvl_o
  );
endinterface

// File: rtl/update_across_bin.sv
// Writes a solved bin's local var/level states back into the global state RAMs.
//
// state  | meaning
// IDLE   | waiting for start_update, write ports released
// VARS   | issuing local var index k = 0..nv-1 to var-map and local var RAMs
// VDRAIN | two cycles letting the last var write retire
// LVLS   | issuing local level j = 1..nl to the local level RAM
// LDRAIN | two cycles letting the last level write retire
// DONE   | completion pulse, cur_lvl_o captured
module update_across_bin #(
  parameter int WIDTH_VARS             = 12,
  parameter int WIDTH_LVL              = 16,
  parameter int WIDTH_VAR_STATES       = 19,
  parameter int WIDTH_LVL_STATES       = 30,
  parameter int ADDR_WIDTH_VARS_STATES = 9,
  parameter int ADDR_WIDTH_LVLS_STATES = 9
) (
  input  logic clk,
  input  logic rst,
  update_across_bin_if.master bus
);

  typedef enum logic [2:0] {IDLE, VARS, VDRAIN, LVLS, LDRAIN, DONE} state_t;

  localparam logic [WIDTH_VARS-1:0] V_ONE = WIDTH_VARS'(1);
  localparam logic [WIDTH_LVL-1:0]  L_ONE = WIDTH_LVL'(1);

  state_t state_q, state_d;

  logic [WIDTH_LVL-1:0]  nl_q;
  logic [WIDTH_LVL-1:0]  base_q;
  logic [WIDTH_VARS-1:0] k_q;
  logic [WIDTH_VARS-1:0] vrem_q;
  logic [WIDTH_LVL-1:0]  j_q;
  logic [WIDTH_LVL-1:0]  lrem_q;
  logic                  drain_q;
  logic [WIDTH_LVL-1:0]  cur_lvl_q;

  logic                  v_pend_q;
  logic                  l_pend_q;
  logic [WIDTH_LVL-1:0]  l_j_q;

  logic                              we_v_q;
  logic [ADDR_WIDTH_VARS_STATES-1:0] waddr_v_q;
  logic [WIDTH_VAR_STATES-1:0]       wdata_v_q;
  logic                              we_l_q;
  logic [ADDR_WIDTH_LVLS_STATES-1:0] addr_l_q;
  logic [WIDTH_LVL_STATES-1:0]       data_l_q;

  logic [2:0]           v_val;
  logic [WIDTH_LVL-1:0] v_lvl;
  logic [WIDTH_LVL-1:0] lvl_rebased;
  logic [WIDTH_LVL-1:0] l_addr_full;
  logic                 v_write;

  assign v_val       = bus.local_rdata_v_i[WIDTH_VAR_STATES-1 -: 3];
  assign v_lvl       = bus.local_rdata_v_i[WIDTH_LVL-1:0];
  assign lvl_rebased = v_lvl + base_q;
  assign l_addr_full = base_q + l_j_q;
  assign v_write     = v_pend_q && (v_val != 3'b000);

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.start_update) begin
          if (bus.nv_bin != '0)      state_d = VARS;
          else if (bus.nl_bin != '0) state_d = LVLS;
          else                       state_d = DONE;
        end
      end
      VARS:   if (vrem_q == '0) state_d = VDRAIN;
      VDRAIN: if (!drain_q) state_d = (nl_q != '0) ? LVLS : DONE;
      LVLS:   if (lrem_q == '0) state_d = LDRAIN;
      LDRAIN: if (!drain_q) state_d = DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Down-counters vrem/lrem terminate the walks; k/j are the issued addresses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      nl_q      <= '0;
      base_q    <= '0;
      k_q       <= '0;
      vrem_q    <= '0;
      j_q       <= '0;
      lrem_q    <= '0;
      drain_q   <= 1'b0;
      cur_lvl_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start_update) begin
            nl_q   <= bus.nl_bin;
            base_q <= bus.base_lvl_i;
            k_q    <= '0;
            vrem_q <= bus.nv_bin - V_ONE;
            j_q    <= L_ONE;
            lrem_q <= bus.nl_bin - L_ONE;
          end
        end
        VARS: begin
          k_q     <= k_q + V_ONE;
          vrem_q  <= vrem_q - V_ONE;
          drain_q <= 1'b1;
        end
        LVLS: begin
          j_q     <= j_q + L_ONE;
          lrem_q  <= lrem_q - L_ONE;
          drain_q <= 1'b1;
        end
        VDRAIN, LDRAIN: drain_q <= 1'b0;
        DONE: cur_lvl_q <= base_q + nl_q;
        default: drain_q <= 1'b0;
      endcase
    end
  end

  // Read data arrives one cycle after the issue; the write is registered off it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      v_pend_q  <= 1'b0;
      l_pend_q  <= 1'b0;
      l_j_q     <= '0;
      we_v_q    <= 1'b0;
      waddr_v_q <= '0;
      wdata_v_q <= '0;
      we_l_q    <= 1'b0;
      addr_l_q  <= '0;
      data_l_q  <= '0;
    end else begin
      v_pend_q  <= (state_q == VARS);
      l_pend_q  <= (state_q == LVLS);
      l_j_q     <= j_q;
      we_v_q    <= v_write;
      waddr_v_q <= v_write ? bus.ram_rdata_vmap_i : '0;
      wdata_v_q <= v_write ? {v_val, lvl_rebased} : '0;
      we_l_q    <= l_pend_q;
      addr_l_q  <= l_pend_q ? l_addr_full[ADDR_WIDTH_LVLS_STATES-1:0] : '0;
      data_l_q  <= l_pend_q ? bus.local_rdata_l_i : '0;
    end
  end

  assign bus.apply_update_o      = (state_q != IDLE);
  assign bus.done_update         = (state_q == DONE);
  assign bus.ram_raddr_vmap_o    = (state_q == VARS) ? k_q : '0;
  assign bus.local_raddr_v_o     = (state_q == VARS) ? k_q : '0;
  assign bus.local_raddr_l_o     = (state_q == LVLS) ? j_q : '0;
  assign bus.ram_we_v_state_o    = we_v_q;
  assign bus.ram_waddr_v_state_o = waddr_v_q;
  assign bus.ram_wdata_v_state_o = wdata_v_q;
  assign bus.ram_we_l_state_o    = we_l_q;
  assign bus.ram_addr_l_state_o  = addr_l_q;
  assign bus.ram_data_l_state_o  = data_l_q;
  assign bus.cur_lvl_o           = cur_lvl_q;

endmodule
